exc_redirect_ctrl: RTL and testbench

//  Sequences exception/ERET commit at write-back: prioritises exception sources of the WB instruction,

---
 rtl/exc_redirect_ctrl.sv | 179 +++++++++++++++++
 tb/tb_exc_redirect_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_redirect_ctrl.sv
// Exception/ERET commit sequencer at WB: CP0 commit, cancel, fetch redirect, flush stall.
// Optional exception counter enabled by defining EXC_PERF_CNT_EN.
module exc_redirect_ctrl #(
   parameter logic [31:0] EXC_ENTRY    = 32'hbfc00380,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_valid,
   input  logic [31:0] wb_pc,
   input  logic        wb_bd,
   input  logic [31:0] wb_dm_addr,
   input  logic        ex_int,
   input  logic        ex_ri,
   input  logic        ex_ov,
   input  logic        ex_sys,
   input  logic        ex_bp,
   input  logic        ex_adel,
   input  logic        ex_ades,
   input  logic        wb_eret,
   input  logic [31:0] cp0_epc,
   input  logic        fetch_addr_ok,
   output logic        cancel,
   output logic        cp0_commit,
   output logic [4:0]  commit_code,
   output logic        commit_bd,
   output logic [31:0] commit_epc,
   output logic        badvaddr_wen,
   output logic [31:0] commit_badvaddr,
   output logic        eret_commit,
   output logic        exc_req,
   output logic [31:0] exc_target,
   output logic        wb_stall,
   output logic [31:0] exc_count
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FLUSH
   } state_t;

   localparam logic [3:0] FLUSH_INIT =
      (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic [31:0] target_q, target_nx;

   logic        fetch_adel;
   logic        exc_any;
   logic        take;
   logic [4:0]  code;
   logic        bva_en;
   logic [31:0] bva;

   assign fetch_adel = (wb_pc[1:0] != 2'b00);
   assign exc_any = ex_int | fetch_adel | ex_ri | ex_ov
                  | ex_sys | ex_bp | ex_adel | ex_ades;
   // Pulses are gated by reset so nothing commits while resetn is low
   assign take = resetn & wb_valid & (state == IDLE);

   always_comb begin
      code   = 5'd0;
      bva_en = 1'b0;
      bva    = 32'd0;
      if (ex_int) begin
         code = 5'd0;
      end else if (fetch_adel) begin
         code   = 5'd4;
         bva_en = 1'b1;
         bva    = wb_pc;
      end else if (ex_ri) begin
         code = 5'd10;
      end else if (ex_ov) begin
         code = 5'd12;
      end else if (ex_sys) begin
         code = 5'd8;
      end else if (ex_bp) begin
         code = 5'd9;
      end else if (ex_adel) begin
         code   = 5'd4;
         bva_en = 1'b1;
         bva    = wb_dm_addr;
      end else if (ex_ades) begin
         code   = 5'd5;
         bva_en = 1'b1;
         bva    = wb_dm_addr;
      end
   end

   always_comb begin
      state_nx        = state;
      cnt_nx          = cnt;
      target_nx       = target_q;
      cancel          = 1'b0;
      cp0_commit      = 1'b0;
      commit_code     = 5'd0;
      commit_bd       = 1'b0;
      commit_epc      = 32'd0;
      badvaddr_wen    = 1'b0;
      commit_badvaddr = 32'd0;
      eret_commit     = 1'b0;
      exc_req         = 1'b0;
      wb_stall        = 1'b0;
      unique case (state)
         IDLE: begin
            if (take && exc_any) begin
               cancel          = 1'b1;
               cp0_commit      = 1'b1;
               commit_code     = code;
               commit_bd       = wb_bd;
               commit_epc      = wb_bd ? wb_pc - 32'd4 : wb_pc;
               badvaddr_wen    = bva_en;
               commit_badvaddr = bva;
               target_nx       = EXC_ENTRY;
               state_nx        = REQ;
            end else if (take && wb_eret) begin
               cancel      = 1'b1;
               eret_commit = 1'b1;
               target_nx   = cp0_epc;
               state_nx    = REQ;
            end
         end
         REQ: begin
            exc_req  = 1'b1;
            wb_stall = 1'b1;
            if (fetch_addr_ok) begin
               if (FLUSH_CYCLES == 0) begin
                  state_nx = IDLE;
               end else begin
                  state_nx = FLUSH;
                  cnt_nx   = FLUSH_INIT;
               end
            end
         end
         FLUSH: begin
            wb_stall = 1'b1;
            if (cnt == 4'd0) begin
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         target_q <= 32'd0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         target_q <= target_nx;
      end
   end

   assign exc_target = target_q;

`ifdef EXC_PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         perf_q <= 32'd0;
      end else if (cp0_commit) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign exc_count = perf_q;
`else
   assign exc_count = 32'd0;
`endif

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Bench for exc_redirect_ctrl: directed scenarios then random traffic vs. a behavioural model.
module tb_exc_redirect_ctrl;

   localparam int FC = 2;
   localparam logic [31:0] ENTRY = 32'hbfc00380;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        wb_valid = 1'b0;
   logic [31:0] wb_pc = 32'd0;
   logic        wb_bd = 1'b0;
   logic [31:0] wb_dm_addr = 32'd0;
   logic        ex_int = 1'b0, ex_ri = 1'b0, ex_ov = 1'b0, ex_sys = 1'b0;
   logic        ex_bp = 1'b0, ex_adel = 1'b0, ex_ades = 1'b0;
   logic        wb_eret = 1'b0;
   logic [31:0] cp0_epc = 32'd0;
   logic        fetch_addr_ok = 1'b0;
   logic        cancel, cp0_commit, commit_bd, badvaddr_wen, eret_commit;
   logic        exc_req, wb_stall;
   logic [4:0]  commit_code;
   logic [31:0] commit_epc, commit_badvaddr, exc_target, exc_count;

   int checks = 0;
   int errors = 0;

   // Model: pending redirect flag, remaining stall cycles, target, counter
   bit          m_req = 1'b0;
   int          m_flush = 0;
   logic [31:0] m_tgt = 32'd0;
   logic [31:0] m_cnt = 32'd0;

   exc_redirect_ctrl #(.EXC_ENTRY(ENTRY), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
      .wb_bd(wb_bd), .wb_dm_addr(wb_dm_addr), .ex_int(ex_int),
      .ex_ri(ex_ri), .ex_ov(ex_ov), .ex_sys(ex_sys), .ex_bp(ex_bp),
      .ex_adel(ex_adel), .ex_ades(ex_ades), .wb_eret(wb_eret),
      .cp0_epc(cp0_epc), .fetch_addr_ok(fetch_addr_ok), .cancel(cancel),
      .cp0_commit(cp0_commit), .commit_code(commit_code),
      .commit_bd(commit_bd), .commit_epc(commit_epc),
      .badvaddr_wen(badvaddr_wen), .commit_badvaddr(commit_badvaddr),
      .eret_commit(eret_commit), .exc_req(exc_req),
      .exc_target(exc_target), .wb_stall(wb_stall), .exc_count(exc_count)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] code_of(int i);
      case (i)
         0: return 5'd0;
         1: return 5'd4;
         2: return 5'd10;
         3: return 5'd12;
         4: return 5'd8;
         5: return 5'd9;
         6: return 5'd4;
         default: return 5'd5;
      endcase
   endfunction

   task automatic clr();
      wb_valid = 0; wb_bd = 0; wb_eret = 0; fetch_addr_ok = 0;
      ex_int = 0; ex_ri = 0; ex_ov = 0; ex_sys = 0;
      ex_bp = 0; ex_adel = 0; ex_ades = 0;
      wb_pc = 32'h8000_0000; wb_dm_addr = 32'd0; cp0_epc = 32'd0;
   endtask

   // Check this cycle against the model, then advance one clock
   task automatic tick();
      logic        flags [8];
      logic        anyexc, bwen, idle, take;
      logic [4:0]  code;
      logic [31:0] bva, epc;
      #3;
      flags = '{ex_int, wb_pc[1:0] != 2'b00, ex_ri, ex_ov,
                ex_sys, ex_bp, ex_adel, ex_ades};
      anyexc = 0; code = 0; bwen = 0; bva = 0;
      for (int i = 0; i < 8; i++) begin
         if (flags[i] && !anyexc) begin
            anyexc = 1;
            code = code_of(i);
            bwen = (i == 1) || (i >= 6);
            bva = (i == 1) ? wb_pc : wb_dm_addr;
         end
      end
      epc = wb_bd ? wb_pc - 32'd4 : wb_pc;
      idle = !m_req && m_flush == 0;
      take = resetn && idle && wb_valid;
      chk("cancel", cancel, take && (anyexc || wb_eret));
      chk("cp0_commit", cp0_commit, take && anyexc);
      chk("eret_commit", eret_commit, take && !anyexc && wb_eret);
      chk("badvaddr_wen", badvaddr_wen, take && anyexc && bwen);
      if (take && anyexc) begin
         chk("commit_code", commit_code, code);
         chk("commit_bd", commit_bd, wb_bd);
         chk("commit_epc", commit_epc, epc);
         if (bwen) chk("badvaddr", commit_badvaddr, bva);
      end
      chk("exc_req", exc_req, m_req);
      chk("wb_stall", wb_stall, m_req || m_flush > 0);
      if (m_req) chk("exc_target", exc_target, m_tgt);
`ifdef EXC_PERF_CNT_EN
      chk("exc_count", exc_count, m_cnt);
`else
      chk("exc_count", exc_count, 32'd0);
`endif
      @(posedge clk);
      if (!resetn) begin
         m_req = 0; m_flush = 0; m_tgt = 0; m_cnt = 0;
      end else if (take && (anyexc || wb_eret)) begin
         m_req = 1;
         m_tgt = anyexc ? ENTRY : cp0_epc;
         if (anyexc) m_cnt = m_cnt + 1;
      end else if (m_req && fetch_addr_ok) begin
         m_req = 0;
         m_flush = FC;
      end else if (m_flush > 0) begin
         m_flush--;
      end
      #1;
   endtask

   task automatic finish_event(int wait_cycles);
      clr();
      for (int i = 0; i < wait_cycles; i++) tick();
      fetch_addr_ok = 1;
      tick();
      clr();
      for (int i = 0; i < FC; i++) tick();
   endtask

   initial begin
      clr();
      resetn = 0;
      tick();
      tick();
      chk("rst_target", exc_target, 32'd0);
      chk("rst_count", exc_count, 32'd0);
      resetn = 1;
      tick();

      // sys, no delay slot, fetch accepts after 3 request cycles
      wb_valid = 1; wb_pc = 32'hbfc00100; ex_sys = 1;
      #3;
      chk("t1_code", commit_code, 32'd8);
      chk("t1_epc", commit_epc, 32'hbfc00100);
      tick();
      chk("t1_target", exc_target, ENTRY);
      finish_event(2);
      chk("t1_idle", wb_stall, 1'b0);

      // ov in delay slot
      wb_valid = 1; wb_pc = 32'h80000010; wb_bd = 1; ex_ov = 1;
      #3;
      chk("t2_epc", commit_epc, 32'h8000000c);
      tick();
      finish_event(0);

      // misaligned fetch beats RI, interrupt beats everything
      wb_valid = 1; wb_pc = 32'h80000002; ex_ri = 1;
      #3;
      chk("t3_code", commit_code, 32'd4);
      chk("t3_bva", commit_badvaddr, 32'h80000002);
      ex_int = 1;
      #1;
      chk("t3_int", commit_code, 32'd0);
      tick();
      finish_event(1);

      // ades then eret
      wb_valid = 1; ex_ades = 1; wb_dm_addr = 32'h1001;
      tick();
      finish_event(1);
      wb_valid = 1; wb_eret = 1; cp0_epc = 32'h80001234;
      tick();
      chk("t4_target", exc_target, 32'h80001234);
      finish_event(0);

      // second event during REQ is dropped; reset in FLUSH aborts
      wb_valid = 1; ex_sys = 1;
      tick();
      tick();
      tick();
      clr();
      fetch_addr_ok = 1;
      tick();
      clr();
      resetn = 0;
      tick();
      resetn = 1;
      #3;
      chk("t5_stall", wb_stall, 1'b0);
      chk("t5_target", exc_target, 32'd0);
      tick();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         resetn = ($urandom_range(199) != 0);
         wb_valid = 1'($urandom_range(1));
         wb_pc = $urandom();
         if ($urandom_range(3) != 0) wb_pc[1:0] = 2'b00;
         wb_bd = 1'($urandom_range(1));
         wb_dm_addr = $urandom();
         ex_int = ($urandom_range(15) == 0);
         ex_ri = ($urandom_range(15) == 0);
         ex_ov = ($urandom_range(15) == 0);
         ex_sys = ($urandom_range(15) == 0);
         ex_bp = ($urandom_range(15) == 0);
         ex_adel = ($urandom_range(15) == 0);
         ex_ades = ($urandom_range(15) == 0);
         wb_eret = ($urandom_range(2) == 0);
         cp0_epc = $urandom();
         fetch_addr_ok = ($urandom_range(2) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
